// File: rtl/l_s_mix_operation.sv
// l_s_mix_operation: RC5 key-schedule mixing stage.
// Walks the S and L tables in place for N = 3*max(T,C) passes:
//   A = S[i] = rotl(S[i] + A + B, 3)
//   B = L[j] = rotl(L[j] + A + B, A + B)
// Each pass takes two cycles. ADDR presents the addresses to both single-port RAMs.
// CALC uses the returned read data to compute and write back both words.
module l_s_mix_operation #(
    parameter int W        = 32,
    parameter int T        = 26,
    parameter int C        = 4,
    parameter int T_LENGTH = $clog2(T),
    parameter int C_LENGTH = $clog2(C),
    parameter int N        = 3 * ((T > C) ? T : C)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iStart,
    input  logic [W-1:0]        iS_sub_i,
    output logic [T_LENGTH-1:0] oS_address,
    output logic [W-1:0]        oS_sub_i_prima,
    output logic                oS_we,
    input  logic [W-1:0]        iL_sub_j,
    output logic [C_LENGTH-1:0] oL_address,
    output logic [W-1:0]        oL_sub_j_prima,
    output logic                oL_we,
    output logic                oBusy,
    output logic                oDone
);

    localparam int SH       = $clog2(W);
    localparam int K_LENGTH = $clog2(N + 1);

    localparam logic [T_LENGTH-1:0] I_LAST = T_LENGTH'(T - 1);
    localparam logic [C_LENGTH-1:0] J_LAST = C_LENGTH'(C - 1);
    localparam logic [K_LENGTH-1:0] K_LAST = K_LENGTH'(N - 1);
    localparam logic [SH-1:0]       ROT_A  = SH'(3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [W-1:0]          a_q, a_d;
    logic [W-1:0]          b_q, b_d;
    logic [T_LENGTH-1:0]   i_q, i_d;
    logic [C_LENGTH-1:0]   j_q, j_d;
    logic [K_LENGTH-1:0]   k_q, k_d;

    logic [W-1:0]          sumA;
    logic [W-1:0]          aNew;
    logic [W-1:0]          sumAB;
    logic [W-1:0]          bNew;
    logic                  inCalc;

    // Left rotate. The doubled word makes a rotate by zero fall out naturally.
    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [SH-1:0] s);
        logic [2*W-1:0] t;
        t = {x, x} << s;
        return t[2*W-1:W];
    endfunction

    // Mixing datapath, meaningful only in CALC when the RAM read data is valid.
    always_comb begin
        sumA  = iS_sub_i + a_q + b_q;
        aNew  = rotl(sumA, ROT_A);
        sumAB = aNew + b_q;
        bNew  = rotl(iL_sub_j + sumAB, sumAB[SH-1:0]);
    end

    // State and working registers. An asynchronous reset aborts a run on the spot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    // Next state and register updates. The indices are frozen on the final pass
    // so the address outputs keep showing the last locations written while in DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;

        case (state_q)
            IDLE, DONE: begin
                if (iStart) begin
                    state_d = ADDR;
                    a_d     = '0;
                    b_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            ADDR: begin
                state_d = CALC;
            end
            CALC: begin
                a_d = aNew;
                b_d = bNew;
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = ADDR;
                    i_d     = (i_q == I_LAST) ? '0 : i_q + 1'b1;
                    j_d     = (j_q == J_LAST) ? '0 : j_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode. Write data is zeroed outside CALC so idle outputs stay quiet.
    always_comb begin
        inCalc         = (state_q == CALC);
        oS_address     = i_q;
        oL_address     = j_q;
        oS_we          = inCalc;
        oL_we          = inCalc;
        oS_sub_i_prima = inCalc ? aNew : '0;
        oL_sub_j_prima = inCalc ? bNew : '0;
        oBusy          = (state_q == ADDR) || (state_q == CALC);
        oDone          = (state_q == DONE);
    end

endmodule
